// File: rtl/xmpl_sram_arb.sv
// xmpl_sram_arb: round-robin arbiter sharing one single-port SRAM among NUM_REQ requesters,
// with a registered SRAM command and a read-tag pipeline that routes read data back to its issuer.
module xmpl_sram_arb #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0]        req_rw_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      en_sram_o,
  output logic [ADDR_W-1:0]         sram_addr_o,
  output logic                      sram_rw_o,
  output logic [DATA_W-1:0]         sram_data_o,
  input  logic [DATA_W-1:0]         sram_data_i
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0]      ptr_q, ptr_d, win;
  logic               acc;
  logic [NUM_REQ-1:0] iss_q;
  logic [NUM_REQ-1:0] tag_q [RD_LAT];
  int                 idx;
  // Scan from the farthest offset down so the requester nearest the pointer is written last and wins.
  always_comb begin
    win = '0;
    idx = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx -= NUM_REQ;
      if (req_valid_i[PW'(idx)]) win = PW'(idx);
    end
  end
  assign acc         = |req_valid_i;
  assign req_ready_o = acc ? NUM_REQ'(1) << win : '0;
  assign ptr_d       = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q       <= '0;
      iss_q       <= '0;
      en_sram_o   <= 1'b0;
      sram_addr_o <= '0;
      sram_rw_o   <= 1'b0;
      sram_data_o <= '0;
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      en_sram_o <= acc;
      if (acc) begin
        ptr_q       <= ptr_d;
        iss_q       <= req_ready_o;
        sram_addr_o <= req_addr_i[int'(win)*ADDR_W +: ADDR_W];
        sram_rw_o   <= req_rw_i[win];
        sram_data_o <= req_wdata_i[int'(win)*DATA_W +: DATA_W];
      end
      // Writes push an empty tag so the pipeline stays aligned with SRAM latency.
      tag_q[0] <= (en_sram_o && !sram_rw_o) ? iss_q : '0;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
      rsp_valid_o <= tag_q[RD_LAT-1];
      if (|tag_q[RD_LAT-1]) rsp_rdata_o <= sram_data_i;
    end
  end
endmodule

// File: tb/tb_xmpl_sram_arb.sv
// tb_xmpl_sram_arb: directed bench for a 2-requester/RD_LAT=1 arbiter and a 4-requester/RD_LAT=3 arbiter,
// with SRAM models and an in-order response scoreboard.
module tb_xmpl_sram_arb;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;
  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc++;

  logic [1:0]   va, ra, rwa, rva;
  logic [23:0]  aa;
  logic [63:0]  wa;
  logic [31:0]  rda, sda_o, sda_i;
  logic         ena, srwa;
  logic [11:0]  saa;
  logic [3:0]   vb, rb, rwb, rvb;
  logic [47:0]  ab;
  logic [127:0] wb;
  logic [31:0]  rdb, sdb_o, sdb_i, pb1, pb2;
  logic         enb, srwb;
  logic [11:0]  sab;

  xmpl_sram_arb dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .req_valid_i(va), .req_ready_o(ra), .req_rw_i(rwa),
    .req_addr_i(aa), .req_wdata_i(wa), .rsp_valid_o(rva), .rsp_rdata_o(rda), .en_sram_o(ena),
    .sram_addr_o(saa), .sram_rw_o(srwa), .sram_data_o(sda_o), .sram_data_i(sda_i));

  xmpl_sram_arb #(.NUM_REQ(4), .RD_LAT(3)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .req_valid_i(vb), .req_ready_o(rb), .req_rw_i(rwb),
    .req_addr_i(ab), .req_wdata_i(wb), .rsp_valid_o(rvb), .rsp_rdata_o(rdb), .en_sram_o(enb),
    .sram_addr_o(sab), .sram_rw_o(srwb), .sram_data_o(sdb_o), .sram_data_i(sdb_i));

  function automatic logic [31:0] init_val(int a);
    return 32'hA500_0000 ^ (32'(a) * 32'h0001_0001);
  endfunction

  logic [31:0] mem_a [4096];
  logic [31:0] mem_b [4096];
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int a = 0; a < 4096; a++) begin
        mem_a[a] <= init_val(a);
        mem_b[a] <= init_val(a);
      end
    end else begin
      if (ena && srwa) mem_a[saa] <= sda_o;
      if (enb && srwb) mem_b[sab] <= sdb_o;
    end
    sda_i <= mem_a[saa];
    pb1   <= mem_b[sab];
    pb2   <= pb1;
    sdb_i <= pb2;
  end

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  typedef struct { int d; logic [3:0] tag; logic [31:0] data; int due; } exp_t;
  exp_t        q[$];
  logic [31:0] ref_mem [2][4096];
  logic        pv [2];
  logic [11:0] pa [2];
  logic        prw [2];
  logic [31:0] pd [2];

  // Expected command one cycle after accept, expected response lat+2 cycles after a read accept.
  task automatic mon(int d, logic [3:0] v, logic [3:0] rdy, logic [3:0] rw, logic [47:0] a,
                     logic [127:0] wd, logic en, logic [11:0] sa, logic srw, logic [31:0] sd,
                     logic [3:0] rv, logic [31:0] rd, int lat);
    int hit;
    if (!reset_n) begin
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].d == d) q.delete(i);
      for (int i = 0; i < 4096; i++) ref_mem[d][i] = init_val(i);
      pv[d] = 1'b0;
      check($sformatf("rst_en%0d", d), 64'(en), 64'd0);
      check($sformatf("rst_rsp%0d", d), 64'(rv), 64'd0);
      return;
    end
    check($sformatf("en%0d", d), 64'(en), 64'(pv[d]));
    if (pv[d]) begin
      check($sformatf("addr%0d", d), 64'(sa), 64'(pa[d]));
      check($sformatf("rw%0d", d), 64'(srw), 64'(prw[d]));
      if (prw[d]) check($sformatf("wdata%0d", d), 64'(sd), 64'(pd[d]));
    end
    hit = -1;
    for (int i = 0; i < q.size(); i++) if (hit < 0 && q[i].d == d) hit = i;
    if (hit >= 0 && q[hit].due <= cyc) begin
      check($sformatf("rsp_tag%0d", d), 64'(rv), 64'(q[hit].tag));
      check($sformatf("rsp_data%0d", d), 64'(rd), 64'(q[hit].data));
      q.delete(hit);
    end else check($sformatf("rsp_idle%0d", d), 64'(rv), 64'd0);
    check($sformatf("rdy_1h%0d", d), 64'($onehot0(rdy)), 64'd1);
    pv[d] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!pv[d] && v[k[1:0]] && rdy[k[1:0]]) begin
        pv[d]  = 1'b1;
        pa[d]  = a[k*12 +: 12];
        prw[d] = rw[k[1:0]];
        pd[d]  = wd[k*32 +: 32];
        if (prw[d]) ref_mem[d][pa[d]] = pd[d];
        else q.push_back('{d, 4'(1 << k), ref_mem[d][pa[d]], cyc + lat + 2});
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, {2'b0, va}, {2'b0, ra}, {2'b0, rwa}, {24'b0, aa}, {64'b0, wa}, ena, saa, srwa, sda_o,
        {2'b0, rva}, rda, 1);
    mon(1, vb, rb, rwb, ab, wb, enb, sab, srwb, sdb_o, rvb, rdb, 3);
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int n0, n1;

  initial begin
    va = '0; rwa = '0; aa = '0; wa = '0;
    vb = '0; rwb = '0; ab = '0; wb = '0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_en", 64'(ena), 64'd0);
    check("rst_rsp", 64'(rva), 64'd0);
    check("rst_addr", 64'(saa), 64'd0);
    check("rst_rdata", 64'(rda), 64'd0);
    check("rst_en_b", 64'(enb), 64'd0);
    step(2);
    reset_n = 1'b1;
    // Idle after reset.
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle", 64'({ena, ra, rva}), 64'd0);
    end
    // Write then read-back of the same address across requesters.
    va = 2'b01; rwa = 2'b01; aa[11:0] = 12'h0A5; wa[31:0] = 32'hDEADBEEF;
    #1 check("wr_ready", 64'(ra), 64'h1);
    step();
    check("wr_en", 64'(ena), 64'd1);
    check("wr_addr", 64'(saa), 64'h0A5);
    check("wr_rw", 64'(srwa), 64'd1);
    check("wr_data", 64'(sda_o), 64'hDEADBEEF);
    va = 2'b10; rwa = 2'b00; aa[23:12] = 12'h0A5;
    #1 check("rd_ready", 64'(ra), 64'h2);
    step();
    check("rd_en", 64'(ena), 64'd1);
    check("rd_rw", 64'(srwa), 64'd0);
    va = 2'b00;
    step();
    check("rd_early", 64'(rva), 64'd0);
    step();
    check("rd_rsp", 64'(rva), 64'h2);
    check("rd_rdata", 64'(rda), 64'hDEADBEEF);
    step();
    check("rd_pulse", 64'(rva), 64'd0);
    check("rd_hold", 64'(rda), 64'hDEADBEEF);
    // Both requesters reading addresses 0..7 alternate strictly.
    n0 = 0; n1 = 0; rwa = 2'b00;
    for (int i = 0; i < 8; i++) begin
      aa = {12'(2 * n1 + 1), 12'(2 * n0)};
      va = 2'b11;
      #1 check("alt_ready", 64'(ra), (i % 2 == 0) ? 64'h1 : 64'h2);
      if (i % 2 == 0) n0++; else n1++;
      step();
    end
    va = 2'b00;
    step(4);
    // Single requester continuously valid is granted every cycle.
    rwa = 2'b10;
    for (int i = 0; i < 5; i++) begin
      va = 2'b10; aa[23:12] = 12'(12'h100 + i); wa[63:32] = 32'h1000 + 32'(i);
      #1 check("solo_ready", 64'(ra), 64'h2);
      step();
      check("solo_en", 64'(ena), 64'd1);
      check("solo_addr", 64'(saa), 64'(12'h100 + i));
    end
    va = 2'b11; rwa = 2'b00; aa = {12'h101, 12'h104};
    #1 check("ptr_wrap", 64'(ra), 64'h1);
    step();
    va = 2'b10;
    #1 check("ptr_next", 64'(ra), 64'h2);
    step();
    va = 2'b00;
    step(4);
    // Four requesters all valid rotate 0,1,2,3,0... with random read/write.
    for (int k = 0; k < 4; k++) begin
      rwb[k] = 1'($urandom);
      ab[k*12 +: 12] = 12'($urandom_range(0, 15));
      wb[k*32 +: 32] = $urandom;
    end
    for (int i = 0; i < 12; i++) begin
      vb = 4'hF;
      #1 check("rot_ready", 64'(rb), 64'(4'b0001 << (i % 4)));
      step();
      rwb[i % 4] = 1'($urandom);
      ab[(i % 4)*12 +: 12] = 12'($urandom_range(0, 15));
      wb[(i % 4)*32 +: 32] = $urandom;
    end
    vb = 4'h0;
    step(8);
    // Reset while two reads are in flight discards them.
    va = 2'b10; rwa = 2'b00; aa = {12'h003, 12'h004};
    #1 check("fl_ready1", 64'(ra), 64'h2);
    step();
    va = 2'b01;
    #1 check("fl_ready0", 64'(ra), 64'h1);
    step();
    va = 2'b00;
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_en", 64'(ena), 64'd0);
    check("mid_rst_rsp", 64'(rva), 64'd0);
    check("mid_rst_addr", 64'(saa), 64'd0);
    check("mid_rst_rdata", 64'(rda), 64'd0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_rsp", 64'(rva), 64'd0);
    end
    va = 2'b11;
    #1 check("post_rst_ptr", 64'(ra), 64'h1);
    step();
    va = 2'b00;
    step(4);
    check("sb_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
